jtsdram_bank_chk: RTL and testbench

Parametrised successor of the single-bank read/write verifier in the sdram48 test core.
- Sweeps one SDRAM bank, generalised in address and data width.
- Runs one of two modes: read-verify against an external reference, or a self-checking write-then-read pass using internally generated patterns.
- Drives the bank request port of the SDRAM controller directly.
- Reports pass/fail, a saturating error count and, optionally, the first failing location.

---
 rtl/jtsdram_bank_pkg.sv | 48 ++++
 rtl/jtsdram_bank_lfsr.sv | 38 +++
 rtl/jtsdram_bank_chk.sv | 225 ++++++++++++++++++++++
 tb/tb_jtsdram_bank_chk.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtsdram_bank_pkg.sv
// ----------------------------------------------------------------------------
// jtsdram_bank_pkg
// Shared types and helpers for the single-bank SDRAM checker.
//   state_t      : checker FSM states (IDLE, GAP, REQ, WAIT, NEXT, DONE)
//   pass_t       : current sweep direction (WRITE, READ)
//   DEFAULT_SEED : default XOR seed for the data pattern
//   LFSR_INIT    : non-zero reset value of the gap LFSR
//   pat()        : data pattern for an address, computed on 64-bit vectors
//                  (callers truncate to their data width; AW and DW <= 64)
// ----------------------------------------------------------------------------
package jtsdram_bank_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        GAP  = 3'd1,
        REQ  = 3'd2,
        WAIT = 3'd3,
        NEXT = 3'd4,
        DONE = 3'd5
    } state_t;

    typedef enum logic {
        WRITE = 1'b0,
        READ  = 1'b1
    } pass_t;

    localparam logic [15:0] DEFAULT_SEED = 16'h5A3C;
    localparam logic [15:0] LFSR_INIT    = 16'hACE1;

    // Repeat the low aw bits of a from the LSB upward, then XOR the seed.
    // The seed is zero-extended here; truncation to the data width happens
    // at the call site, so a narrow data bus simply drops upper seed bits.
    function automatic logic [63:0] pat(
        input logic [63:0] a,
        input int unsigned aw,
        input logic [15:0] seed
    );
        logic [63:0] rep;
        int unsigned j;
        rep = {64{1'b0}};
        for (int unsigned i = 0; i < 64; i++) begin
            j = i % aw;
            rep[i] = a[j];
        end
        return rep ^ {48'h0000_0000_0000, seed};
    endfunction

endpackage

// File: rtl/jtsdram_bank_lfsr.sv
// ----------------------------------------------------------------------------
// jtsdram_bank_lfsr
// Free-running 16-bit maximal-length Fibonacci LFSR
// (x^16 + x^14 + x^13 + x^11 + 1). Advances every clock; resets to a
// non-zero constant so it can never lock up.
// Ports:
//   clk   in   system clock
//   rst_n in   asynchronous active-low reset
//   gap   out  low nibble of the LFSR, used as a random inter-request gap
// ----------------------------------------------------------------------------
module jtsdram_bank_lfsr
    import jtsdram_bank_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] gap
);

    logic [15:0] lfsr_r;
    logic        fb_s;

    // Feedback tap combination for the maximal-length polynomial.
    always_comb begin
        fb_s = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];
    end

    // Shift register; runs regardless of what the checker is doing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r <= LFSR_INIT;
        end else begin
            lfsr_r <= {lfsr_r[14:0], fb_s};
        end
    end

    assign gap = lfsr_r[3:0];

endmodule

// File: rtl/jtsdram_bank_chk.sv
// ----------------------------------------------------------------------------
// jtsdram_bank_chk
// Sweeps one SDRAM bank through the controller's bank request port.
// mode 0: read every word and compare against data_ref.
// mode 1: write pat(a) to every word, then read back and compare to pat(a).
// Optional build macro JTSDRAM_BANK_ERRLOG_EN: when defined, err_addr and
// err_data hold the first mismatch of the current test; otherwise they are
// tied to zero.
// Parameters: AW address width (<= 64), DW data width (<= 64), SEED pattern
// seed, ECW error counter width.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, mode, slow test control (mode sampled at start)
//   addr, rd, wr, din request to the controller (held until ack)
//   ack, rdy, dout    controller accept / completion / read data
//   data_ref          reference read data for mode 0, valid with rdy
//   busy, done, bad   status (done and bad are sticky until next start)
//   err_cnt           saturating mismatch count
//   err_addr,err_data first failing location (optional)
// ----------------------------------------------------------------------------
module jtsdram_bank_chk
    import jtsdram_bank_pkg::*;
#(
    parameter int          AW   = 22,
    parameter int          DW   = 16,
    parameter logic [15:0] SEED = DEFAULT_SEED,
    parameter int          ECW  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           mode,
    input  logic           slow,
    output logic [AW-1:0]  addr,
    output logic           rd,
    output logic           wr,
    output logic [DW-1:0]  din,
    input  logic           ack,
    input  logic           rdy,
    input  logic [DW-1:0]  dout,
    input  logic [DW-1:0]  data_ref,
    output logic           busy,
    output logic           done,
    output logic           bad,
    output logic [ECW-1:0] err_cnt,
    output logic [AW-1:0]  err_addr,
    output logic [DW-1:0]  err_data
);

    localparam logic [AW-1:0]  ADDR_MAX = {AW{1'b1}};
    localparam logic [AW-1:0]  ADDR_ONE = AW'(1'b1);
    localparam logic [ECW-1:0] ERR_MAX  = {ECW{1'b1}};
    localparam logic [ECW-1:0] ERR_ONE  = ECW'(1'b1);

    state_t        state_r;
    pass_t         pass_r;
    logic          mode_r;
    logic [3:0]    gap_r;
    logic [3:0]    lfsr_gap_s;
    logic [3:0]    gap_load_s;
    logic [DW-1:0] pat_s;
    logic [DW-1:0] exp_s;
    logic          xfer_end_s;
    logic          check_s;
    logic          mismatch_s;

    jtsdram_bank_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .gap   (lfsr_gap_s)
    );

    // Pattern for the current address and the value a read must return.
    always_comb begin
        pat_s = DW'(pat(64'(addr), AW, SEED));
        if (mode_r) begin
            exp_s = pat_s;
        end else begin
            exp_s = data_ref;
        end
    end

    // Gap length loaded on every entry into GAP: random when slow, else none.
    always_comb begin
        if (slow) begin
            gap_load_s = lfsr_gap_s;
        end else begin
            gap_load_s = 4'd0;
        end
    end

    // An access completes on rdy in WAIT, or on ack+rdy together in REQ.
    // A rdy seen in REQ without ack belongs to nobody and is ignored.
    always_comb begin
        if (state_r == REQ) begin
            xfer_end_s = ack & rdy;
        end else if (state_r == WAIT) begin
            xfer_end_s = rdy;
        end else begin
            xfer_end_s = 1'b0;
        end
        check_s    = xfer_end_s & (pass_r == READ) & ~start;
        mismatch_s = check_s & (dout != exp_s);
    end

    // Main sequencer: request generation, sweep control and status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            pass_r  <= WRITE;
            mode_r  <= 1'b0;
            gap_r   <= 4'd0;
            addr    <= {AW{1'b0}};
            rd      <= 1'b0;
            wr      <= 1'b0;
            din     <= {DW{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            bad     <= 1'b0;
            err_cnt <= {ECW{1'b0}};
        end else if (start) begin
            // Restart from any state, abandoning any request in flight.
            state_r <= GAP;
            pass_r  <= mode ? WRITE : READ;
            mode_r  <= mode;
            gap_r   <= gap_load_s;
            addr    <= {AW{1'b0}};
            rd      <= 1'b0;
            wr      <= 1'b0;
            busy    <= 1'b1;
            done    <= 1'b0;
            bad     <= 1'b0;
            err_cnt <= {ECW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= IDLE;
                end
                GAP: begin
                    if (gap_r == 4'd0) begin
                        state_r <= REQ;
                        if (pass_r == WRITE) begin
                            wr  <= 1'b1;
                            din <= pat_s;
                        end else begin
                            rd  <= 1'b1;
                        end
                    end else begin
                        gap_r <= gap_r - 4'd1;
                    end
                end
                REQ: begin
                    if (ack) begin
                        rd      <= 1'b0;
                        wr      <= 1'b0;
                        state_r <= rdy ? NEXT : WAIT;
                    end
                end
                WAIT: begin
                    if (rdy) begin
                        state_r <= NEXT;
                    end
                end
                NEXT: begin
                    if (addr != ADDR_MAX) begin
                        addr    <= addr + ADDR_ONE;
                        gap_r   <= gap_load_s;
                        state_r <= GAP;
                    end else if (pass_r == WRITE) begin
                        pass_r  <= READ;
                        addr    <= {AW{1'b0}};
                        gap_r   <= gap_load_s;
                        state_r <= GAP;
                    end else begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    state_r <= DONE;
                end
                default: begin
                    state_r <= IDLE;
                    rd      <= 1'b0;
                    wr      <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase

            if (mismatch_s) begin
                bad <= 1'b1;
                if (err_cnt != ERR_MAX) begin
                    err_cnt <= err_cnt + ERR_ONE;
                end
            end
        end
    end

`ifdef JTSDRAM_BANK_ERRLOG_EN
    logic [AW-1:0] err_addr_r;
    logic [DW-1:0] err_data_r;

    // First-failure capture: bad is still clear only on the first mismatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_addr_r <= {AW{1'b0}};
            err_data_r <= {DW{1'b0}};
        end else if (start) begin
            err_addr_r <= {AW{1'b0}};
            err_data_r <= {DW{1'b0}};
        end else if (mismatch_s && !bad) begin
            err_addr_r <= addr;
            err_data_r <= dout;
        end
    end

    assign err_addr = err_addr_r;
    assign err_data = err_data_r;
`else
    assign err_addr = {AW{1'b0}};
    assign err_data = {DW{1'b0}};
`endif

endmodule

// File: tb/tb_jtsdram_bank_chk.sv
// ----------------------------------------------------------------------------
// tb_jtsdram_bank_chk
// Bench for jtsdram_bank_chk with AW=4, DW=16, ECW=3. A behavioural SDRAM
// controller answers requests with configurable ack/rdy delays, keeps a
// 16-word memory and logs every request it accepts. Expected results come
// from the pattern rule pat(a) = {a,a,a,a} ^ 16'h5A3C and the sweep order.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_jtsdram_bank_chk;

    localparam int AW  = 4;
    localparam int DW  = 16;
    localparam int ECW = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           mode = 1'b0;
    logic           slow = 1'b0;
    logic           ack = 1'b0;
    logic           rdy = 1'b0;
    logic [DW-1:0]  dout = 16'h0000;
    logic [DW-1:0]  data_ref = 16'h0000;
    logic [AW-1:0]  addr;
    logic           rd;
    logic           wr;
    logic [DW-1:0]  din;
    logic           busy;
    logic           done;
    logic           bad;
    logic [ECW-1:0] err_cnt;
    logic [AW-1:0]  err_addr;
    logic [DW-1:0]  err_data;

    int checks = 0;
    int failures = 0;

    // controller model configuration
    int  ack_min = 0, ack_max = 0, rdy_min = 2, rdy_max = 2;
    int  corrupt_addr = -1;
    bit  ref_bad = 1'b0;
    bit  spurious = 1'b0;
    int  proto_err = 0;
    logic [DW-1:0] mem [16];

    typedef struct {
        bit            w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } acc_t;
    acc_t log_q[$];

    jtsdram_bank_chk #(
        .AW   (AW),
        .DW   (DW),
        .SEED (16'h5A3C),
        .ECW  (ECW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mode     (mode),
        .slow     (slow),
        .addr     (addr),
        .rd       (rd),
        .wr       (wr),
        .din      (din),
        .ack      (ack),
        .rdy      (rdy),
        .dout     (dout),
        .data_ref (data_ref),
        .busy     (busy),
        .done     (done),
        .bad      (bad),
        .err_cnt  (err_cnt),
        .err_addr (err_addr),
        .err_data (err_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] mpat(input int a);
        logic [3:0] n;
        n = a[3:0];
        return {n, n, n, n} ^ 16'h5A3C;
    endfunction

    // Number of deviations of the request log from the expected sweep.
    function automatic int log_errors(input bit m);
        int e;
        int n;
        e = 0;
        n = m ? 32 : 16;
        if (log_q.size() != n) e++;
        for (int i = 0; i < n && i < log_q.size(); i++) begin
            bit ew;
            int ea;
            ew = m && (i < 16);
            ea = i % 16;
            if (log_q[i].w != ew || int'(log_q[i].a) != ea) e++;
            else if (ew && log_q[i].d !== mpat(ea)) e++;
        end
        return e;
    endfunction

    // Behavioural controller: accept, ack after a delay, rdy after another.
    initial begin : ctl
        int cst;
        int ad;
        int rdl;
        bit cw;
        logic [AW-1:0] ca;
        cst = 0; ad = 0; rdl = 0; cw = 1'b0; ca = 4'h0;
        forever begin
            @(negedge clk);
            ack = 1'b0;
            rdy = 1'b0;
            if (!rst_n) begin
                cst = 0;
            end else begin
                if (cst == 1 && !((cw ? wr : rd) && addr == ca)) proto_err++;
                if (cst == 2 && (rd || wr)) proto_err++;
                if (cst == 0 && (rd || wr)) begin
                    if (rd && wr) proto_err++;
                    cw = wr;
                    ca = addr;
                    log_q.push_back('{wr, addr, din});
                    ad  = $urandom_range(ack_max, ack_min);
                    rdl = $urandom_range(rdy_max, rdy_min);
                    cst = 1;
                end
                if (cst == 1) begin
                    if (ad == 0) begin
                        ack = 1'b1;
                        if (cw) mem[ca] = din;
                        if (rdl == 0) cst = 3; else cst = 2;
                    end else begin
                        ad--;
                        if (spurious && !cw && $urandom_range(1, 0) == 1) begin
                            rdy = 1'b1;
                            dout = ~mem[ca];
                            data_ref = mem[ca];
                        end
                    end
                end else if (cst == 2) begin
                    rdl--;
                    if (rdl == 0) cst = 3;
                end
                if (cst == 3) begin
                    rdy = 1'b1;
                    if (cw) begin
                        dout = 16'($urandom);
                        data_ref = 16'($urandom);
                    end else begin
                        dout = mem[ca] ^ ((int'(ca) == corrupt_addr) ? 16'h0001 : 16'h0000);
                        data_ref = ref_bad ? ~mem[ca] : mem[ca];
                    end
                    cst = 0;
                end
            end
        end
    end

    task automatic start_test(input bit m, input bit s);
        @(negedge clk);
        mode = m;
        slow = s;
        start = 1'b1;
        log_q.delete();
        proto_err = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name, output int cyc);
        cyc = 0;
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s_done: done=%0b expected 1 after %0d cycles", name, done, cyc);
        end
    endtask

    task automatic test_reset();
        #23;
        checks++;
        if ({rd, wr, busy, done, bad} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_flags: rd/wr/busy/done/bad=%b expected 00000", {rd, wr, busy, done, bad});
        end
        checks++;
        if (addr !== 4'h0 || din !== 16'h0000 || err_cnt !== 3'h0) begin
            failures++;
            $display("FAIL reset_regs: addr=%h din=%h err_cnt=%h expected 0", addr, din, err_cnt);
        end
        checks++;
        if (err_addr !== 4'h0 || err_data !== 16'h0000) begin
            failures++;
            $display("FAIL reset_errlog: err_addr=%h err_data=%h expected 0", err_addr, err_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rd !== 1'b0 || wr !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b rd=%b wr=%b expected 0", busy, rd, wr);
        end
    endtask

    task automatic test_write_read(output int cyc);
        ack_min = 0; ack_max = 0; rdy_min = 2; rdy_max = 2;
        corrupt_addr = -1; ref_bad = 1'b0; spurious = 1'b0;
        start_test(1'b1, 1'b0);
        wait_done(3000, "wr_rd", cyc);
        checks++;
        if (bad !== 1'b0 || err_cnt !== 3'h0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL wr_rd_status: bad=%b err_cnt=%h busy=%b expected 0/0/0", bad, err_cnt, busy);
        end
        checks++;
        if (log_errors(1'b1) != 0 || proto_err != 0) begin
            failures++;
            $display("FAIL wr_rd_seq: log_errors=%0d proto_err=%0d entries=%0d expected 0/0/32",
                     log_errors(1'b1), proto_err, log_q.size());
        end
    endtask

    task automatic test_corrupt();
        int cyc;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        ack_min = 0; ack_max = 0; rdy_min = 2; rdy_max = 2;
        corrupt_addr = 9; ref_bad = 1'b0; spurious = 1'b0;
        start_test(1'b1, 1'b0);
        wait_done(3000, "corrupt", cyc);
        corrupt_addr = -1;
        checks++;
        if (bad !== 1'b1 || err_cnt !== 3'h1) begin
            failures++;
            $display("FAIL corrupt_count: bad=%b err_cnt=%h expected 1/1", bad, err_cnt);
        end
`ifdef JTSDRAM_BANK_ERRLOG_EN
        ea = 4'h9;
        ed = mpat(9) ^ 16'h0001;
`else
        ea = 4'h0;
        ed = 16'h0000;
`endif
        checks++;
        if (err_addr !== ea || err_data !== ed) begin
            failures++;
            $display("FAIL corrupt_log: err_addr=%h err_data=%h expected %h/%h", err_addr, err_data, ea, ed);
        end
    endtask

    task automatic test_saturate();
        int cyc;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
        ack_min = 0; ack_max = 1; rdy_min = 0; rdy_max = 2;
        corrupt_addr = -1; ref_bad = 1'b1; spurious = 1'b0;
        start_test(1'b0, 1'b0);
        wait_done(3000, "sat", cyc);
        ref_bad = 1'b0;
        checks++;
        if (err_cnt !== 3'h7 || bad !== 1'b1) begin
            failures++;
            $display("FAIL sat_count: err_cnt=%h bad=%b expected 7/1", err_cnt, bad);
        end
        checks++;
        if (log_errors(1'b0) != 0 || proto_err != 0) begin
            failures++;
            $display("FAIL sat_seq: log_errors=%0d proto_err=%0d expected 0/0", log_errors(1'b0), proto_err);
        end
`ifdef JTSDRAM_BANK_ERRLOG_EN
        ea = 4'h0;
        ed = mem[0];
`else
        ea = 4'h0;
        ed = 16'h0000;
`endif
        checks++;
        if (err_addr !== ea || err_data !== ed) begin
            failures++;
            $display("FAIL sat_log: err_addr=%h err_data=%h expected %h/%h", err_addr, err_data, ea, ed);
        end
    endtask

    task automatic test_slow(input int fast_cyc);
        int cyc;
        // Fixed controller timing: the only extra time comes from the gaps.
        ack_min = 0; ack_max = 0; rdy_min = 2; rdy_max = 2;
        corrupt_addr = -1; ref_bad = 1'b0; spurious = 1'b0;
        start_test(1'b1, 1'b1);
        wait_done(6000, "slow_fixed", cyc);
        checks++;
        if (cyc < fast_cyc + 64 || cyc > fast_cyc + 32 * 15) begin
            failures++;
            $display("FAIL slow_gap: cycles=%0d expected between %0d and %0d",
                     cyc, fast_cyc + 64, fast_cyc + 32 * 15);
        end
        // Random ack/rdy delays, coincident ack+rdy and stray rdy before ack.
        for (int r = 0; r < 2; r++) begin
            bit m;
            m = (r == 0);
            if (!m) for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
            ack_min = 0; ack_max = 5; rdy_min = 0; rdy_max = 5; spurious = 1'b1;
            start_test(m, 1'b1);
            wait_done(8000, "slow_rand", cyc);
            checks++;
            if (log_errors(m) != 0 || proto_err != 0) begin
                failures++;
                $display("FAIL slow_rand_seq: mode=%0b log_errors=%0d proto_err=%0d expected 0/0",
                         m, log_errors(m), proto_err);
            end
            checks++;
            if (bad !== 1'b0 || err_cnt !== 3'h0) begin
                failures++;
                $display("FAIL slow_rand_status: mode=%0b bad=%b err_cnt=%h expected 0/0", m, bad, err_cnt);
            end
        end
        spurious = 1'b0;
        slow = 1'b0;
    endtask

    task automatic test_restart();
        int cyc;
        int n;
        ack_min = 0; ack_max = 0; rdy_min = 2; rdy_max = 2;
        corrupt_addr = -1; ref_bad = 1'b0; spurious = 1'b0;
        start_test(1'b1, 1'b0);
        n = 0;
        while (!(addr == 4'h6 && !wr && !rd && busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (addr !== 4'h6) begin
            failures++;
            $display("FAIL restart_reach: addr=%h expected 6", addr);
        end
        start = 1'b1;
        log_q.delete();
        proto_err = 0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (addr !== 4'h0 || err_cnt !== 3'h0 || bad !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL restart_clear: addr=%h err_cnt=%h bad=%b done=%b busy=%b expected 0/0/0/0/1",
                     addr, err_cnt, bad, done, busy);
        end
        wait_done(3000, "restart", cyc);
        checks++;
        if (log_errors(1'b1) != 0 || proto_err != 0 || bad !== 1'b0) begin
            failures++;
            $display("FAIL restart_seq: log_errors=%0d proto_err=%0d bad=%b expected 0/0/0",
                     log_errors(1'b1), proto_err, bad);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        ack_min = 3; ack_max = 3; rdy_min = 1; rdy_max = 1;
        start_test(1'b0, 1'b0);
        n = 0;
        while (rd !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rd !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_req: rd=%b expected 1", rd);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rd !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || wr !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_async: rd=%b wr=%b busy=%b done=%b expected 0", rd, wr, busy, done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rd !== 1'b0 || wr !== 1'b0 || addr !== 4'h0 || done !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_idle: busy=%b rd=%b wr=%b addr=%h done=%b expected 0",
                     busy, rd, wr, addr, done);
        end
    endtask

    initial begin
        int fast_cyc;
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        test_reset();
        test_write_read(fast_cyc);
        test_corrupt();
        test_saturate();
        test_slow(fast_cyc);
        test_restart();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
